// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad (PmodKYPD-style) by pulling one column low at a
//   time and reading the rows back. It debounces whole scans, pulses once per
//   accepted key and shifts each accepted hex digit into a 16-bit entry
//   register.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high; clears all state
//   col        out  4   column drive, active-low one-hot
//   row        in   4   row sense, active-low, asynchronous to clk
//   key_valid  out  1   one-clk pulse when a key is accepted
//   key_code   out  4   hex code of the last accepted key
//   key_down   out  1   high from accept until the release is accepted
//   value      out  16  entry register, {value[11:0], key_code} on each accept
//
// Parameters
//   SCAN_DIV      clk cycles each column is driven (>= 4)
//   DEBOUNCE      identical full scans needed to accept a press or a release
//   REPEAT_DELAY  full scans held before the first auto-repeat
//   REPEAT_RATE   full scans between later auto-repeats
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, a held key auto-repeats; when undefined the
//                     REPEAT_* parameters are ignored and a press emits once.

module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 25_000,
  parameter int unsigned DEBOUNCE     = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [15:0] value
);

  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
  localparam int unsigned STAB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchronizer (rows idle high through the external pull-ups)
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Column scan
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] dwell;
  logic [1:0]       col_idx;
  logic             sample;
  logic             scan_done;

  // Sampling on the last dwell cycle leaves SCAN_DIV-1 cycles for the row
  // lines plus the two synchronizer stages to settle after a column change.
  assign sample    = (dwell == DIV_LAST);
  assign scan_done = sample && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell   <= '0;
      col_idx <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell   <= dwell + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Key bitmap, bit 4*r+c = key at row r / column c is down
  // ---------------------------------------------------------------------------
  logic [15:0] bitmap;
  logic [15:0] bitmap_next;

  always_comb begin
    bitmap_next = bitmap;
    if (sample) begin
      for (int unsigned r = 0; r < 4; r++) begin
        bitmap_next[{r[1:0], col_idx}] = ~row_sync[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap <= '0;
    end else begin
      bitmap <= bitmap_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan classification (evaluated on the bitmap including the final column)
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] map_key(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'h0;
      4'd13:   code = 4'hF;
      4'd14:   code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [1:0] hits;      // saturating: 0, 1, 2 = two or more
  logic [3:0] hit_pos;
  logic       scan_single;
  logic       scan_none;
  logic [3:0] scan_code;

  always_comb begin
    hits    = '0;
    hit_pos = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (bitmap_next[i]) begin
        if (hits != 2'd2) begin
          hits = hits + 2'd1;
        end
        hit_pos = 4'(i);
      end
    end
    scan_single = (hits == 2'd1);
    scan_none   = (hits == 2'd0);
    scan_code   = map_key(hit_pos);
  end

  // ---------------------------------------------------------------------------
  // Debounce / emission FSM, advanced once per full scan
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_n;
  logic [STAB_W-1:0] stab;
  logic [STAB_W-1:0] stab_n;
  logic [3:0]        cand;
  logic [3:0]        cand_n;
  logic              down_n;
  logic              emit;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_n;
  logic             rpt_rate;     // first repeat already issued for this hold
  logic             rpt_rate_n;
`endif

  always_comb begin
    state_n = state;
    stab_n  = stab;
    cand_n  = cand;
    down_n  = key_down;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_n  = rpt_cnt;
    rpt_rate_n = rpt_rate;
`endif

    if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_single) begin
            cand_n = scan_code;
            stab_n = STAB_ONE;
            if (STAB_ONE == STAB_MAX) begin
              state_n = HELD;
              emit    = 1'b1;
              down_n  = 1'b1;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end

        PRESS_DB: begin
          if (scan_single && (scan_code == cand)) begin
            stab_n = stab + STAB_ONE;
            if (stab_n == STAB_MAX) begin
              state_n = HELD;
              emit    = 1'b1;
              down_n  = 1'b1;
            end
          end else if (scan_single) begin
            cand_n = scan_code;
            stab_n = STAB_ONE;
          end else begin
            state_n = IDLE;
            stab_n  = '0;
          end
        end

        HELD: begin
          // Any other key, or several keys, keeps the hold: a new key is only
          // taken after the current one has been released.
          if (scan_none) begin
            stab_n = STAB_ONE;
            if (STAB_ONE == STAB_MAX) begin
              state_n = IDLE;
              down_n  = 1'b0;
            end else begin
              state_n = REL_DB;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rpt_cnt_n = rpt_cnt + RPT_W'(1);
            if (rpt_cnt_n == (rpt_rate ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY))) begin
              emit       = 1'b1;
              rpt_cnt_n  = '0;
              rpt_rate_n = 1'b1;
            end
          end
`endif
        end

        REL_DB: begin
          if (scan_none) begin
            stab_n = stab + STAB_ONE;
            if (stab_n == STAB_MAX) begin
              state_n = IDLE;
              down_n  = 1'b0;
            end
          end else begin
            state_n = HELD;
          end
        end

        default: begin
          state_n = IDLE;
          stab_n  = '0;
        end
      endcase
    end

`ifdef KEYPAD_REPEAT_EN
    // Any path other than HELD->HELD (accept, release start, release abort)
    // restarts the repeat delay.
    if ((state != HELD) || (state_n != HELD)) begin
      rpt_cnt_n  = '0;
      rpt_rate_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stab      <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
      value     <= '0;
    end else begin
      state     <= state_n;
      stab      <= stab_n;
      cand      <= cand_n;
      key_valid <= emit;
      key_down  <= down_n;
      if (emit) begin
        key_code <= cand_n;
        value    <= {value[11:0], cand_n};
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt  <= '0;
      rpt_rate <= 1'b0;
    end else begin
      rpt_cnt  <= rpt_cnt_n;
      rpt_rate <= rpt_rate_n;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with a small scan period. A behavioural
//   keypad drives row from col and the set of pressed keys. Expected accepts
//   ({key_code, value}) are queued when a press is driven and popped when the
//   DUT pulses key_valid. Stimulus changes on full-scan boundaries.

module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE     = 3;
  localparam int unsigned REPEAT_DELAY = 6;
  localparam int unsigned REPEAT_RATE  = 2;
  localparam int unsigned SCAN_CLKS    = 4 * SCAN_DIV;

  // Bitmap positions (4*row + col) of the keys used below
  localparam logic [15:0] K1 = 16'h0001;  // r0 c0
  localparam logic [15:0] K2 = 16'h0002;  // r0 c1
  localparam logic [15:0] K3 = 16'h0004;  // r0 c2
  localparam logic [15:0] KA = 16'h0008;  // r0 c3
  localparam logic [15:0] K4 = 16'h0010;  // r1 c0
  localparam logic [15:0] K5 = 16'h0020;  // r1 c1
  localparam logic [15:0] K6 = 16'h0040;  // r1 c2
  localparam logic [15:0] K7 = 16'h0100;  // r2 c0
  localparam logic [15:0] K9 = 16'h0400;  // r2 c2
  localparam logic [15:0] KF = 16'h2000;  // r3 c1

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] value;

  logic [15:0] pressed = '0;
  logic [15:0] exp_value = '0;
  logic [19:0] sb_q[$];
  logic [19:0] sb_ent;
  logic [3:0]  exp_cols [4];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int base;

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++) begin
      if ((pressed[4*r +: 4] & ~col) != 4'b0000) begin
        row[r] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .value     (value)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_value = {exp_value[11:0], code};
    sb_q.push_back({code, exp_value});
  endtask

  // Hold a key set for a whole number of scans; returns 1 time unit after a
  // rising edge that starts the next scan.
  task automatic step(input logic [15:0] mask, input int unsigned scans);
    pressed = mask;
    repeat (scans * SCAN_CLKS) @(posedge clk);
    #1;
  endtask

  // Accept monitor / scoreboard
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_pulses++;
      n_checks++;
      assert (sb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse: observed key_code %h value %h, expected no pulse",
               key_code, value);
      end
      if (sb_q.size() > 0) begin
        sb_ent = sb_q.pop_front();
        check("pulse_code", {12'b0, key_code}, {12'b0, sb_ent[19:16]});
        check("pulse_value", value, sb_ent[15:0]);
      end
    end
  end

  initial begin
    exp_cols[0] = 4'b1110;
    exp_cols[1] = 4'b1101;
    exp_cols[2] = 4'b1011;
    exp_cols[3] = 4'b0111;

    // 1: reset state and column rotation
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", {12'b0, col}, 16'h000E);
    check("rst_value", value, 16'h0000);
    check("rst_key_valid", {15'b0, key_valid}, 16'h0000);
    check("rst_key_down", {15'b0, key_down}, 16'h0000);
    check("rst_key_code", {12'b0, key_code}, 16'h0000);
    reset   = 1'b0;
    pressed = '0;
    for (int i = 0; i < 4; i++) begin
      check("col_step", {12'b0, col}, {12'b0, exp_cols[i]});
      repeat (SCAN_DIV) @(posedge clk);
      #1;
    end
    check("col_wrap", {12'b0, col}, 16'h000E);

    // 2: '5' held 10 scans, released
    expect_key(4'h5);
    step(K5, 10);
    check("k5_pulses", 16'(n_pulses), 16'd1);
    check("k5_code", {12'b0, key_code}, 16'h0005);
    check("k5_value", value, 16'h0005);
    check("k5_down", {15'b0, key_down}, 16'h0001);
    step('0, 2);
    check("k5_rel2_down", {15'b0, key_down}, 16'h0001);
    step('0, 1);
    check("k5_rel3_down", {15'b0, key_down}, 16'h0000);
    check("k5_rel_code", {12'b0, key_code}, 16'h0005);

    // 3: 1,2,3,4 then A, each pressed exactly DEBOUNCE scans
    expect_key(4'h1);
    step(K1, 3);
    check("k1_accept_edge", {15'b0, key_valid}, 16'h0001);
    step('0, 3);
    expect_key(4'h2);
    step(K2, 3);
    step('0, 3);
    expect_key(4'h3);
    step(K3, 3);
    step('0, 3);
    expect_key(4'h4);
    step(K4, 3);
    step('0, 3);
    check("seq_1234", value, 16'h1234);
    expect_key(4'hA);
    step(KA, 3);
    step('0, 3);
    check("seq_234A", value, 16'h234A);

    // No rollover: switching 5 -> 6 without a release emits only the 5
    base = n_pulses;
    expect_key(4'h5);
    step(K5, 4);
    step(K6, 5);
    step('0, 3);
    check("rollover_pulses", 16'(n_pulses - base), 16'd1);
    check("rollover_value", value, 16'h34A5);

    // 4: bounce and multi-key produce nothing
    base = n_pulses;
    step(K7, 2);
    check("bounce_no_valid", {15'b0, key_valid}, 16'h0000);
    step('0, 1);
    step(K7, 2);
    step('0, 3);
    step(K1 | K2, 10);
    step('0, 3);
    check("bounce_multi_pulses", 16'(n_pulses - base), 16'd0);
    check("bounce_multi_value", value, 16'h34A5);
    check("bounce_multi_down", {15'b0, key_down}, 16'h0000);

    // 5: reset during PRESS_DB of '9'
    base = n_pulses;
    step(K9, 2);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_col", {12'b0, col}, 16'h000E);
    check("midrst_value", value, 16'h0000);
    check("midrst_key_code", {12'b0, key_code}, 16'h0000);
    check("midrst_key_down", {15'b0, key_down}, 16'h0000);
    check("midrst_key_valid", {15'b0, key_valid}, 16'h0000);
    exp_value = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_key(4'h9);
    step(K9, 2);
    check("midrst_no_early_pulse", 16'(n_pulses - base), 16'd0);
    step(K9, 1);
    check("k9_accept_valid", {15'b0, key_valid}, 16'h0001);
    check("k9_value", value, 16'h0009);
    step('0, 3);

    // 6: 'F' held 14 scans
    base = n_pulses;
`ifdef KEYPAD_REPEAT_EN
    expect_key(4'hF);   // accept, scan 3
    expect_key(4'hF);   // accept + REPEAT_DELAY
    expect_key(4'hF);   // + REPEAT_RATE
    expect_key(4'hF);   // + REPEAT_RATE
    step(KF, 14);
    step('0, 3);
    check("kF_repeat_pulses", 16'(n_pulses - base), 16'd4);
    check("kF_repeat_value", value, 16'hFFFF);
`else
    expect_key(4'hF);
    step(KF, 14);
    step('0, 3);
    check("kF_single_pulse", 16'(n_pulses - base), 16'd1);
    check("kF_value", value, 16'h009F);
`endif
    check("kF_released", {15'b0, key_down}, 16'h0000);

    repeat (2) @(posedge clk);
    check("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
